cp0_timer: RTL and testbench



---
 rtl/cp0_timer.sv | 83 ++++++++
 tb/tb_cp0_timer.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/cp0_timer.sv
// CP0 Count/Compare timer: prescaled free-running Count, sticky Compare
// match interrupt (ti) and a one-cycle wrap pulse when Count rolls over.
module cp0_timer #(
    parameter int               WIDTH         = 32,
    parameter logic [WIDTH-1:0] RESET_COUNT   = WIDTH'(1),
    parameter logic [WIDTH-1:0] RESET_COMPARE = '1,
    parameter int               DIV           = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             count_we,
    input  logic             compare_we,
    input  logic [WIDTH-1:0] wdata,
    input  logic             stall,
    output logic [WIDTH-1:0] count_q,
    output logic [WIDTH-1:0] compare_q,
    output logic             ti,
    output logic             wrap
);

    localparam int            PW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PMAX = PW'(DIV - 1);

    logic [PW-1:0]    pre_q;
    logic [PW-1:0]    pre_d;
    logic [WIDTH-1:0] count_d;
    logic [WIDTH-1:0] compare_d;
    logic             ti_d;
    logic             wrap_d;
    logic             tick;
    logic             match;

    always_comb begin
        tick      = !stall && (pre_q == PMAX) && !count_we;
        match     = (count_q == compare_q);
        pre_d     = pre_q;
        count_d   = count_q;
        compare_d = compare_q;
        ti_d      = ti;
        wrap_d    = tick && (count_q == '1);

        // A Count write restarts the prescale period, even under stall.
        if (count_we) begin
            pre_d = '0;
        end else if (!stall) begin
            pre_d = (pre_q == PMAX) ? '0 : pre_q + PW'(1);
        end

        if (count_we) begin
            count_d = wdata;
        end else if (tick) begin
            count_d = count_q + WIDTH'(1);
        end

        if (compare_we) begin
            compare_d = wdata;
        end

        // Acknowledge beats a coincident match.
        if (compare_we) begin
            ti_d = 1'b0;
        end else if (match) begin
            ti_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pre_q     <= '0;
            count_q   <= RESET_COUNT;
            compare_q <= RESET_COMPARE;
            ti        <= 1'b0;
            wrap      <= 1'b0;
        end else begin
            pre_q     <= pre_d;
            count_q   <= count_d;
            compare_q <= compare_d;
            ti        <= ti_d;
            wrap      <= wrap_d;
        end
    end

endmodule

// File: tb/tb_cp0_timer.sv
// Scoreboard bench for cp0_timer: a DIV=1 and a DIV=4 instance share
// stimulus; each queued expectation names which instance it checks.
module tb_cp0_timer;

    localparam logic [31:0] FF = 32'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst;
    logic        count_we;
    logic        compare_we;
    logic [31:0] wdata;
    logic        stall;

    logic [31:0] c1, m1, c4, m4;
    logic        ti1, w1, ti4, w4;

    always #5 clk = ~clk;

    cp0_timer #(.DIV(1)) u_d1 (
        .clk(clk), .rst(rst), .count_we(count_we), .compare_we(compare_we),
        .wdata(wdata), .stall(stall),
        .count_q(c1), .compare_q(m1), .ti(ti1), .wrap(w1)
    );

    cp0_timer #(.DIV(4)) u_d4 (
        .clk(clk), .rst(rst), .count_we(count_we), .compare_we(compare_we),
        .wdata(wdata), .stall(stall),
        .count_q(c4), .compare_q(m4), .ti(ti4), .wrap(w4)
    );

    typedef struct {
        int          sel;
        logic [31:0] cnt;
        logic [31:0] cmp;
        logic        ti;
        logic        wrap;
        string       nm;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    task automatic cyc(input bit r, input bit st, input bit cwe, input bit mwe,
                       input logic [31:0] wd, input int sel,
                       input logic [31:0] ec, input logic [31:0] em,
                       input bit eti, input bit ew, input string nm);
        exp_t e;
        rst        = r;
        stall      = st;
        count_we   = cwe;
        compare_we = mwe;
        wdata      = wd;
        e.sel  = sel;
        e.cnt  = ec;
        e.cmp  = em;
        e.ti   = eti;
        e.wrap = ew;
        e.nm   = nm;
        q.push_back(e);
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string nm, input string f,
                       input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s.%s: got %h expected %h at %0t",
                     nm, f, act, exp, $time);
        end
    endtask

    // Monitor: every clock presents a new output state.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                if (e.sel == 0) begin
                    chk(e.nm, "count", c1, e.cnt);
                    chk(e.nm, "compare", m1, e.cmp);
                    chk(e.nm, "ti", {31'b0, ti1}, {31'b0, e.ti});
                    chk(e.nm, "wrap", {31'b0, w1}, {31'b0, e.wrap});
                end else begin
                    chk(e.nm, "count", c4, e.cnt);
                    chk(e.nm, "compare", m4, e.cmp);
                    chk(e.nm, "ti", {31'b0, ti4}, {31'b0, e.ti});
                    chk(e.nm, "wrap", {31'b0, w4}, {31'b0, e.wrap});
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; stall = 1'b0; count_we = 1'b0;
        compare_we = 1'b0; wdata = '0;
        #2;

        // Reset and free run, DIV=1
        cyc(1, 0, 0, 0, 0, 1, 1, FF, 0, 0, "rst_d4");
        cyc(1, 0, 0, 0, 0, 0, 1, FF, 0, 0, "rst_d1");
        cyc(0, 0, 0, 0, 0, 0, 2, FF, 0, 0, "run2");
        cyc(0, 0, 0, 0, 0, 0, 3, FF, 0, 0, "run3");

        // Compare match and sticky ti
        cyc(0, 0, 1, 0, 5, 0, 5, FF, 0, 0, "ld5");
        cyc(0, 0, 0, 1, 10, 0, 6, 10, 0, 0, "cmp10");
        for (int i = 7; i <= 10; i++)
            cyc(0, 0, 0, 0, 0, 0, i, 10, 0, 0, "pre_match");
        for (int i = 11; i <= 20; i++)
            cyc(0, 0, 0, 0, 0, 0, i, 10, 1, 0, "ti_sticky");
        cyc(0, 0, 0, 1, 50, 0, 21, 50, 0, 0, "ti_ack");
        cyc(0, 0, 0, 0, 0, 0, 22, 50, 0, 0, "ti_clr");

        // Clear beats coincident match; count_we onto Compare
        cyc(0, 0, 1, 1, 5, 0, 5, 5, 0, 0, "both_we");
        cyc(0, 0, 0, 1, 7, 0, 6, 7, 0, 0, "cmp7");
        cyc(0, 0, 0, 0, 0, 0, 7, 7, 0, 0, "eq7");
        cyc(0, 0, 0, 1, 7, 0, 8, 7, 0, 0, "clr_wins");
        cyc(0, 0, 0, 0, 0, 0, 9, 7, 0, 0, "past7");
        cyc(0, 0, 0, 1, 50, 0, 10, 50, 0, 0, "cmp50");
        cyc(0, 0, 1, 0, 50, 0, 50, 50, 0, 0, "ld50");
        cyc(0, 0, 0, 0, 0, 0, 51, 50, 1, 0, "ti_ld");
        cyc(0, 0, 0, 1, 32'hFFFF_FFF0, 0, 52, 32'hFFFF_FFF0, 0, 0, "ack2");

        // Wrap pulse
        cyc(0, 0, 1, 0, 32'hFFFF_FFFE, 0, 32'hFFFF_FFFE, 32'hFFFF_FFF0, 0, 0, "ldFE");
        cyc(0, 0, 0, 0, 0, 0, FF, 32'hFFFF_FFF0, 0, 0, "atFF");
        cyc(0, 0, 0, 0, 0, 0, 0, 32'hFFFF_FFF0, 0, 1, "wrap");
        cyc(0, 0, 0, 0, 0, 0, 1, 32'hFFFF_FFF0, 0, 0, "wrap_end");
        cyc(0, 0, 1, 0, 0, 0, 0, 32'hFFFF_FFF0, 0, 0, "ld0");
        cyc(0, 0, 0, 0, 0, 0, 1, 32'hFFFF_FFF0, 0, 0, "ld0_nowrap");

        // Stall priority, ti under stall, reset under stall
        cyc(0, 1, 1, 0, 100, 0, 100, 32'hFFFF_FFF0, 0, 0, "stall_ld");
        cyc(0, 1, 0, 0, 0, 0, 100, 32'hFFFF_FFF0, 0, 0, "stall_hold");
        cyc(0, 1, 0, 1, 100, 0, 100, 100, 0, 0, "stall_cmp");
        cyc(0, 1, 0, 0, 0, 0, 100, 100, 1, 0, "stall_ti");
        cyc(1, 1, 0, 0, 0, 0, 1, FF, 0, 0, "stall_rst");

        // Prescaler, DIV=4
        cyc(1, 0, 0, 0, 0, 1, 1, FF, 0, 0, "d4_rst");
        for (int i = 0; i < 3; i++)
            cyc(0, 0, 0, 0, 0, 1, 1, FF, 0, 0, "d4_p1");
        cyc(0, 0, 0, 0, 0, 1, 2, FF, 0, 0, "d4_tick2");
        for (int i = 0; i < 3; i++)
            cyc(0, 0, 0, 0, 0, 1, 2, FF, 0, 0, "d4_p2");
        cyc(0, 0, 0, 0, 0, 1, 3, FF, 0, 0, "d4_tick3");
        for (int i = 0; i < 2; i++)
            cyc(0, 0, 0, 0, 0, 1, 3, FF, 0, 0, "d4_p3");
        for (int i = 0; i < 3; i++)
            cyc(0, 1, 0, 0, 0, 1, 3, FF, 0, 0, "d4_stall");
        cyc(0, 0, 0, 0, 0, 1, 3, FF, 0, 0, "d4_resume");
        cyc(0, 0, 0, 0, 0, 1, 4, FF, 0, 0, "d4_tick4");
        for (int i = 0; i < 2; i++)
            cyc(0, 0, 0, 0, 0, 1, 4, FF, 0, 0, "d4_p4");
        cyc(0, 0, 1, 0, 200, 1, 200, FF, 0, 0, "d4_ld");
        for (int i = 0; i < 3; i++)
            cyc(0, 0, 0, 0, 0, 1, 200, FF, 0, 0, "d4_restart");
        cyc(0, 0, 0, 0, 0, 1, 201, FF, 0, 0, "d4_tick201");

        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain: %0d expectations left, expected 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
